// File: rtl/flash_boot_copier.sv
// Boot copier: streams WORDS 32-bit words from SPI flash into program memory and holds the CPU until done.
// Optional trailing-checksum verification is enabled with `define FLASH_BOOT_CHECKSUM_EN.
module flash_boot_copier #(
   parameter int          WORDS      = 4096,
   parameter logic [23:0] FLASH_BASE = 24'h100000,
   parameter logic [29:0] MEM_BASE   = 30'h0,
   parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        flash_req,
   output logic [23:0] flash_addr,
   input  logic        flash_ack,
   input  logic [31:0] flash_rdata,
   output logic        mem_wen,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_select,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [15:0] words_copied
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WRITE,
      FIN,
`ifdef FLASH_BOOT_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } state_t;

   localparam logic [15:0] LAST_IDX = 16'(WORDS - 1);
   localparam logic [15:0] TMO_LAST = TIMEOUT - 16'd1;

   state_t      state, state_n;
   logic [1:0]  ecode, ecode_n;
   logic [15:0] idx;
   logic [15:0] tmo;
   logic [31:0] word_p0;
   logic        in_req, accept, tmo_fire, req_n;

   function automatic logic [23:0] flash_word_addr(input logic [15:0] i);
      return FLASH_BASE + {6'b0, i, 2'b00};
   endfunction

   function automatic logic [29:0] mem_word_addr(input logic [15:0] i);
      return MEM_BASE + {14'b0, i};
   endfunction

`ifdef FLASH_BOOT_CHECKSUM_EN
   logic [31:0] sum_p0;
   assign in_req = (state == REQ) || (state == CHK);
`else
   assign in_req = (state == REQ);
`endif

   // The request line is registered, so an ack only counts once flash_req is visible to the flash side.
   assign accept   = in_req && flash_req && flash_ack;
   assign tmo_fire = in_req && flash_req && !flash_ack && (tmo == TMO_LAST);
   assign req_n    = in_req && !accept && !tmo_fire;

   always_comb begin
      state_n = state;
      ecode_n = ecode;
      case (state)
         IDLE:  if (start) state_n = REQ;
         REQ: begin
            if (accept) begin
               state_n = WRITE;
            end else if (tmo_fire) begin
               state_n = ERR;
               ecode_n = 2'b01;
            end
         end
         WRITE: state_n = (idx == LAST_IDX) ? FIN : REQ;
`ifdef FLASH_BOOT_CHECKSUM_EN
         FIN:   state_n = CHK;
         CHK: begin
            if (accept) begin
               if (flash_rdata == sum_p0) begin
                  state_n = DONE;
               end else begin
                  state_n = ERR;
                  ecode_n = 2'b10;
               end
            end else if (tmo_fire) begin
               state_n = ERR;
               ecode_n = 2'b01;
            end
         end
`else
         FIN:   state_n = DONE;
`endif
         DONE:  state_n = DONE;
         ERR:   state_n = ERR;
         default: state_n = IDLE;
      endcase
   end

   // Control and output stage: every output is a register decoded from the current state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         ecode           <= 2'b00;
         idx             <= '0;
         tmo             <= '0;
         flash_req       <= 1'b0;
         flash_addr      <= '0;
         mem_wen         <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_byte_select <= 4'b0000;
         cpu_hold        <= 1'b1;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         err_code        <= 2'b00;
         words_copied    <= '0;
      end else begin
         state           <= state_n;
         ecode           <= ecode_n;
         tmo             <= (in_req && flash_req) ? tmo + 16'd1 : 16'd0;
         flash_req       <= req_n;
         flash_addr      <= req_n ? flash_word_addr(idx) : 24'd0;
         mem_wen         <= (state == WRITE);
         mem_addr        <= (state == WRITE) ? mem_word_addr(idx) : 30'd0;
         mem_wdata       <= (state == WRITE) ? word_p0 : 32'd0;
         mem_byte_select <= {4{state == WRITE}};
         // idx also advances past the last word so the checksum read addresses word WORDS.
         if (state == WRITE) begin
            idx          <= idx + 16'd1;
            words_copied <= words_copied + 16'd1;
         end
         busy            <= !(state inside {IDLE, DONE, ERR});
         done            <= (state == DONE);
         cpu_hold        <= (state != DONE);
         error           <= (state == ERR);
         err_code        <= (state == ERR) ? ecode : 2'b00;
      end
   end

   // Capture stage: flash data is held for the following write.
   always_ff @(posedge clk) begin
      if (accept) word_p0 <= flash_rdata;
   end

`ifdef FLASH_BOOT_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (state == IDLE) sum_p0 <= '0;
      else if (state == WRITE) sum_p0 <= sum_p0 + word_p0;
   end
`endif

endmodule

// File: tb/tb_flash_boot_copier.sv
// Testbench for flash_boot_copier: table-driven runs against a flash/memory reference model,
// plus hand sequences for zero-wait spacing, stray inputs and reset mid-copy.
module tb_flash_boot_copier;

   localparam int          TB_WORDS = 4;
   localparam logic [23:0] TB_FB    = 24'hFFFFF8;
   localparam logic [29:0] TB_MB    = 30'h3FFFFFFE;
   localparam logic [15:0] TB_TMO   = 16'd16;
   localparam int          NV       = 9;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flash_req;
   logic [23:0] flash_addr;
   logic        flash_ack;
   logic [31:0] flash_rdata;
   logic        mem_wen;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_select;
   logic        cpu_hold, busy, done, error;
   logic [1:0]  err_code;
   logic [15:0] words_copied;

   flash_boot_copier #(
      .WORDS(TB_WORDS), .FLASH_BASE(TB_FB), .MEM_BASE(TB_MB), .TIMEOUT(TB_TMO)
   ) dut (
      .clk(clk), .reset(rst), .start(start),
      .flash_req(flash_req), .flash_addr(flash_addr), .flash_ack(flash_ack), .flash_rdata(flash_rdata),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_select(mem_byte_select),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .err_code(err_code),
      .words_copied(words_copied)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_faddr(input int i);
      return TB_FB + 24'(4 * i);
   endfunction

   function automatic logic [29:0] exp_maddr(input int i);
      return TB_MB + 30'(i);
   endfunction

   // Flash image (word TB_WORDS is the checksum word) and flash behaviour knobs
   logic [31:0] image [0:TB_WORDS];
   int lat_min = 0, lat_max = 0, ack_limit = -1;
   bit stray_ack = 1'b0;

   // Flash model state (written only by the flash model process)
   int req_n, cur_idx, cnt, cur_lat, acks_given, cur_run, last_run;
   bit prev_req;
   int req_rises[$];

   initial begin
      flash_ack = 1'b0;
      flash_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            flash_ack = 1'b0; cnt = 0; req_n = 0; cur_idx = 0; acks_given = 0;
            cur_run = 0; last_run = 0; prev_req = 1'b0; req_rises.delete();
         end else begin
            if (flash_req) begin
               if (!prev_req) begin
                  req_rises.push_back(cyc);
                  cur_idx = req_n;
                  req_n++;
                  cur_lat = int'($urandom_range(lat_max, lat_min));
                  cnt = 0;
               end
               check("flash_addr", flash_addr, exp_faddr(cur_idx));
               cur_run++;
            end else if (prev_req) begin
               last_run = cur_run;
               cur_run = 0;
            end
            if (flash_ack) begin
               flash_ack = 1'b0;
            end else if (flash_req) begin
               if (cnt == cur_lat && !(ack_limit >= 0 && acks_given >= ack_limit)) begin
                  flash_ack = 1'b1;
                  flash_rdata = image[cur_idx];
                  acks_given++;
               end
               cnt++;
            end else if (stray_ack) begin
               flash_ack = 1'b1;
               flash_rdata = 32'hDEADBEEF;
            end
            prev_req = flash_req;
         end
      end
   end

   // Program-memory monitor
   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
      int          c;
   } wr_t;
   wr_t got[$];
   int wen_cnt;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            wen_cnt = 0;
            got.delete();
         end else if (mem_wen) begin
            wen_cnt++;
            got.push_back('{mem_addr, mem_wdata, cyc});
            check("words_copied_step", words_copied, wen_cnt);
            check("bsel_on", mem_byte_select, 4'hF);
         end else begin
            check("bsel_off", mem_byte_select, 4'h0);
         end
      end
   end

   typedef struct {
      int         lat_min;
      int         lat_max;
      int         ack_limit;
      bit         chk_bad;
      int         data_mode;
      bit         exp_done;
      bit         exp_err;
      logic [1:0] exp_code;
      int         exp_words;
   } vec_t;
   vec_t vecs [NV];

   task automatic check_reset_vals(input string tag);
      check({tag, "_flash_req"}, flash_req, 0);
      check({tag, "_flash_addr"}, flash_addr, 0);
      check({tag, "_mem_wen"}, mem_wen, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_bsel"}, mem_byte_select, 0);
      check({tag, "_cpu_hold"}, cpu_hold, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_err_code"}, err_code, 0);
      check({tag, "_words"}, words_copied, 0);
   endtask

   task automatic do_reset(input bit chk);
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (chk) check_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done || error) break;
         @(negedge clk);
      end
      if (!(done || error)) check({tag, "_end_wait"}, 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic fill_image(input int mode, input bit bad);
      logic [31:0] s;
      s = 32'h0;
      for (int i = 0; i < TB_WORDS; i++) begin
         case (mode)
            1:       image[i] = 32'h11 * (i + 1);
            2:       image[i] = i + 1;
            default: image[i] = $urandom;
         endcase
         s = s + image[i];
      end
      image[TB_WORDS] = bad ? s + 32'd1 : s;
   endtask

   task automatic compare_writes(input string tag, input int n);
      check({tag, "_n_writes"}, got.size(), n);
      for (int i = 0; i < got.size() && i < n; i++) begin
         check($sformatf("%s_waddr%0d", tag, i), got[i].addr, exp_maddr(i));
         check($sformatf("%s_wdata%0d", tag, i), got[i].data, image[i]);
      end
   endtask

   task automatic run_vec(input vec_t v, input int n);
      string tag;
      tag = $sformatf("v%0d", n);
      lat_min = v.lat_min;
      lat_max = v.lat_max;
      ack_limit = v.ack_limit;
      fill_image(v.data_mode, v.chk_bad);
      do_reset(n == 0);
      pulse_start();
      wait_end(tag, 1000);
      check({tag, "_done"}, done, v.exp_done);
      check({tag, "_error"}, error, v.exp_err);
      check({tag, "_err_code"}, err_code, v.exp_code);
      check({tag, "_cpu_hold"}, cpu_hold, !v.exp_done);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_flash_req"}, flash_req, 0);
      check({tag, "_words"}, words_copied, v.exp_words);
      compare_writes(tag, v.exp_words);
      if (v.exp_code == 2'b01) check({tag, "_tmo_req_cycles"}, last_run, TB_TMO);
   endtask

   task automatic hand_zero_wait();
      lat_min = 0;
      lat_max = 0;
      ack_limit = -1;
      fill_image(0, 1'b0);
      do_reset(1'b0);
      stray_ack = 1'b1;
      repeat (3) @(negedge clk);
      stray_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("stray_busy", busy, 0);
      check("stray_req", flash_req, 0);
      check("stray_writes", got.size(), 0);
      pulse_start();
      for (int i = 0; i < 500 && got.size() < 2; i++) @(negedge clk);
      pulse_start();
      wait_end("zw", 1000);
      check("zw_done", done, 1);
      check("zw_words", words_copied, TB_WORDS);
      compare_writes("zw", TB_WORDS);
      check("zw_n_reqs", req_rises.size(), TB_WORDS);
      for (int i = 1; i < req_rises.size(); i++)
         check($sformatf("zw_req_gap%0d", i), req_rises[i] - req_rises[i-1], 3);
      for (int i = 1; i < got.size(); i++)
         check($sformatf("zw_wen_gap%0d", i), got[i].c - got[i-1].c, 3);
      if (got.size() > 0 && req_rises.size() > 0)
         check("zw_req_to_wen", got[0].c - req_rises[0], 2);
      pulse_start();
      repeat (10) @(negedge clk);
      check("sticky_done", done, 1);
      check("sticky_writes", got.size(), TB_WORDS);
      check("sticky_req", flash_req, 0);
   endtask

   task automatic hand_reset_mid();
      int seen;
      lat_min = 3;
      lat_max = 3;
      ack_limit = -1;
      fill_image(1, 1'b0);
      do_reset(1'b0);
      pulse_start();
      seen = 0;
      for (int i = 0; i < 500 && seen < 2; i++) begin
         @(negedge clk);
         if (mem_wen) seen++;
      end
      check("rm_two_wen", seen, 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("rm");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rm_idle_writes", got.size(), 0);
      check("rm_idle_busy", busy, 0);
      pulse_start();
      wait_end("rm", 1000);
      check("rm_done", done, 1);
      check("rm_cpu_hold", cpu_hold, 0);
      check("rm_words", words_copied, TB_WORDS);
      compare_writes("rm", TB_WORDS);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      vecs[0] = '{3, 3, -1, 1'b0, 1, 1'b1, 1'b0, 2'b00, 4};
      vecs[1] = '{0, 0, -1, 1'b0, 0, 1'b1, 1'b0, 2'b00, 4};
      vecs[2] = '{0, 5, -1, 1'b0, 0, 1'b1, 1'b0, 2'b00, 4};
      vecs[3] = '{15, 15, -1, 1'b0, 0, 1'b1, 1'b0, 2'b00, 4};
      vecs[4] = '{16, 16, -1, 1'b0, 0, 1'b0, 1'b1, 2'b01, 0};
      vecs[5] = '{1, 1, 2, 1'b0, 0, 1'b0, 1'b1, 2'b01, 2};
      vecs[6] = '{2, 2, -1, 1'b0, 2, 1'b1, 1'b0, 2'b00, 4};
`ifdef FLASH_BOOT_CHECKSUM_EN
      vecs[7] = '{2, 2, -1, 1'b1, 2, 1'b0, 1'b1, 2'b10, 4};
`else
      vecs[7] = '{2, 2, -1, 1'b1, 2, 1'b1, 1'b0, 2'b00, 4};
`endif
      vecs[8] = '{0, 7, -1, 1'b0, 0, 1'b1, 1'b0, 2'b00, 4};
      for (int v = 0; v < NV; v++) run_vec(vecs[v], v);
      hand_zero_wait();
      hand_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
